// File: rtl/star_spawn_ctrl.sv
// star_spawn_ctrl: frame-rate controller for the two collectible star slots.
// Tracks the alive and respawn state of each slot, turns v_sync into a frame
// tick, paces respawns through a round-robin arbiter with a frame gap, and
// keeps a saturating score.
module star_spawn_ctrl #(
  parameter int unsigned RESPAWN_FRAMES = 30,
  parameter int unsigned SPAWN_GAP      = 8,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v_sync,
  input  logic               game_en,
  input  logic               score_clr,
  input  logic               s1_hit,
  input  logic               s2_hit,
  output logic               s1_alive,
  output logic               s2_alive,
  output logic               frame_tick,
  output logic               collect_pulse,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_READY,
    ST_ALIVE,
    ST_DEAD
  } slot_state_t;

  localparam logic [7:0] RESPAWN_LOAD = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] GAP_LOAD     = 8'(SPAWN_GAP);

  // v_sync synchronizer and edge detector
  logic vs_meta;
  logic vs_sync;
  logic vs_prev;

  // per-slot state; index 0 is star 1, index 1 is star 2
  slot_state_t state_q [2];
  slot_state_t state_d [2];
  logic [7:0]  cnt_q   [2];
  logic [7:0]  cnt_d   [2];

  // spawn arbiter
  logic [7:0] gap_q;
  logic [7:0] gap_d;
  logic       ptr_q;
  logic       ptr_d;
  logic [1:0] hit;
  logic [1:0] ready;
  logic [1:0] grant;
  logic [1:0] hit_valid;

  // score path
  logic [1:0]         hit_cnt;
  logic [SCORE_W:0]   score_base;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_d;

  // Synchronize v_sync and register a one-cycle pulse on its rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_meta    <= 1'b0;
      vs_sync    <= 1'b0;
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= v_sync;
      vs_sync    <= vs_meta;
      vs_prev    <= vs_sync;
      frame_tick <= vs_sync & ~vs_prev;
    end
  end

  // Qualify hits, pick at most one READY slot per frame and advance the gap counter.
  always_comb begin
    hit       = {s2_hit, s1_hit};
    ready     = '0;
    hit_valid = '0;
    grant     = '0;
    ptr_d     = ptr_q;
    gap_d     = gap_q;
    for (int unsigned i = 0; i < 2; i++) begin
      ready[i]     = (state_q[i] == ST_READY);
      hit_valid[i] = game_en && (state_q[i] == ST_ALIVE) && hit[i];
    end
    if (game_en && frame_tick && (gap_q == '0)) begin
      if (&ready) begin
        grant[ptr_q] = 1'b1;
        ptr_d        = ~ptr_q;
      end else begin
        grant = ready;
      end
    end
    if (!game_en) begin
      gap_d = '0;
    end else if (|grant) begin
      gap_d = GAP_LOAD;
    end else if (frame_tick && (gap_q != '0)) begin
      gap_d = gap_q - 8'd1;
    end
  end

  // Per-slot next state: disable wins, then hit, countdown and grant handling.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!game_en) begin
        state_d[i] = ST_OFF;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          ST_OFF: begin
            state_d[i] = ST_READY;
          end
          ST_READY: begin
            if (grant[i]) begin
              state_d[i] = ST_ALIVE;
            end
          end
          ST_ALIVE: begin
            if (hit[i]) begin
              state_d[i] = ST_DEAD;
              cnt_d[i]   = RESPAWN_LOAD;
            end
          end
          ST_DEAD: begin
            if (frame_tick) begin
              if (cnt_q[i] == 8'd1) begin
                state_d[i] = ST_READY;
                cnt_d[i]   = '0;
              end else begin
                cnt_d[i] = cnt_q[i] - 8'd1;
              end
            end
          end
          default: begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Saturating score; a clear only drops the old value, same-cycle hits still count.
  always_comb begin
    hit_cnt    = {1'b0, hit_valid[0]} + {1'b0, hit_valid[1]};
    score_base = score_clr ? '0 : {1'b0, score};
    score_sum  = score_base + (SCORE_W + 1)'(hit_cnt);
    score_d    = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  // State, countdown, arbiter and score registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      gap_q         <= '0;
      ptr_q         <= 1'b0;
      score         <= '0;
      collect_pulse <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      gap_q         <= gap_d;
      ptr_q         <= ptr_d;
      score         <= score_d;
      collect_pulse <= |hit_valid;
    end
  end

  // Alive flags decode straight from the state registers.
  always_comb begin
    s1_alive = (state_q[0] == ST_ALIVE);
    s2_alive = (state_q[1] == ST_ALIVE);
  end

endmodule

// File: tb/tb_star_spawn_ctrl.sv
// tb_star_spawn_ctrl: directed bench for star_spawn_ctrl. A default-parameter
// instance covers reset, spawn pacing, respawn, round-robin and disable; a fast
// instance (respawn 1, gap 0) reaches score saturation in few frames.
module tb_star_spawn_ctrl;

  logic       clk;
  logic       rst;
  logic       v_sync;
  logic       game_en;
  logic       score_clr;
  logic       s1_hit;
  logic       s2_hit;
  logic       s1_alive;
  logic       s2_alive;
  logic       frame_tick;
  logic       collect_pulse;
  logic [7:0] score;

  logic       f1_hit;
  logic       f2_hit;
  logic       f1_alive;
  logic       f2_alive;
  logic       f_tick;
  logic       f_collect;
  logic [7:0] f_score;

  int unsigned checks;
  int unsigned failures;
  int unsigned ticks_seen;
  int unsigned collects;

  star_spawn_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .v_sync        (v_sync),
    .game_en       (game_en),
    .score_clr     (score_clr),
    .s1_hit        (s1_hit),
    .s2_hit        (s2_hit),
    .s1_alive      (s1_alive),
    .s2_alive      (s2_alive),
    .frame_tick    (frame_tick),
    .collect_pulse (collect_pulse),
    .score         (score)
  );

  star_spawn_ctrl #(
    .RESPAWN_FRAMES (1),
    .SPAWN_GAP      (0),
    .SCORE_W        (8)
  ) u_fast (
    .clk           (clk),
    .rst           (rst),
    .v_sync        (v_sync),
    .game_en       (game_en),
    .score_clr     (score_clr),
    .s1_hit        (f1_hit),
    .s2_hit        (f2_hit),
    .s1_alive      (f1_alive),
    .s2_alive      (f2_alive),
    .frame_tick    (f_tick),
    .collect_pulse (f_collect),
    .score         (f_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // v_sync high for 'hold' cycles, then enough idle cycles for the grant to show
  task automatic frame(input int unsigned hold);
    v_sync     = 1'b1;
    ticks_seen = 0;
    for (int unsigned c = 0; c < hold; c++) begin
      @(negedge clk);
      if (frame_tick) ticks_seen++;
    end
    v_sync = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (frame_tick) ticks_seen++;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    game_en   = 1'b0;
    v_sync    = 1'b0;
    score_clr = 1'b0;
    s1_hit    = 1'b0;
    s2_hit    = 1'b0;
    f1_hit    = 1'b0;
    f2_hit    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    do_reset();

    check_eq("rst_s1_alive", {31'd0, s1_alive}, 32'd0);
    check_eq("rst_s2_alive", {31'd0, s2_alive}, 32'd0);
    check_eq("rst_tick", {31'd0, frame_tick}, 32'd0);
    check_eq("rst_collect", {31'd0, collect_pulse}, 32'd0);
    check_eq("rst_score", {24'd0, score}, 32'd0);

    // enable, then one v_sync pulse: tick after 2nd edge, s1 alive after 3rd
    game_en = 1'b1;
    repeat (2) @(negedge clk);
    v_sync = 1'b1;
    @(negedge clk);
    check_eq("tick_lat_e0", {31'd0, frame_tick}, 32'd0);
    v_sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("tick_lat_e2", {31'd0, frame_tick}, 32'd1);
    check_eq("s1_not_yet", {31'd0, s1_alive}, 32'd0);
    @(negedge clk);
    check_eq("s1_granted", {31'd0, s1_alive}, 32'd1);
    check_eq("s2_first_off", {31'd0, s2_alive}, 32'd0);
    check_eq("score_start", {24'd0, score}, 32'd0);
    check_eq("tick_single", {31'd0, frame_tick}, 32'd0);

    // gap of 8: s2 spawns on the 9th tick after s1's grant
    for (int unsigned k = 1; k <= 9; k++) begin
      frame((k == 1) ? 6 : 1);
      if (k == 1) check_eq("long_vsync_ticks", ticks_seen, 32'd1);
      check_eq($sformatf("gap_s2_tick%0d", k), {31'd0, s2_alive}, (k == 9) ? 32'd1 : 32'd0);
    end

    // s1 hit held 3 cycles counts once
    collects = 0;
    s1_hit   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (collect_pulse) collects++;
    end
    s1_hit = 1'b0;
    @(negedge clk);
    if (collect_pulse) collects++;
    check_eq("hit_collects", collects, 32'd1);
    check_eq("hit_score", {24'd0, score}, 32'd1);
    check_eq("hit_s1_dead", {31'd0, s1_alive}, 32'd0);
    check_eq("hit_s2_kept", {31'd0, s2_alive}, 32'd1);

    // 30 frames dead, respawn on tick 31
    for (int unsigned k = 1; k <= 31; k++) begin
      frame(1);
      if (k >= 29) check_eq($sformatf("respawn_tick%0d", k), {31'd0, s1_alive}, (k == 31) ? 32'd1 : 32'd0);
    end

    // s1 dead mid-countdown, then disable with s2 alive
    s1_hit = 1'b1;
    @(negedge clk);
    s1_hit = 1'b0;
    check_eq("pre_dis_score", {24'd0, score}, 32'd2);
    repeat (3) frame(1);
    game_en = 1'b0;
    @(negedge clk);
    check_eq("dis_s1", {31'd0, s1_alive}, 32'd0);
    check_eq("dis_s2", {31'd0, s2_alive}, 32'd0);
    check_eq("dis_score_held", {24'd0, score}, 32'd2);
    frame(1);
    check_eq("dis_no_spawn", {30'd0, s2_alive, s1_alive}, 32'd0);

    // re-enable: both READY, pointer at slot 2 -> s2 first, s1 after the gap
    game_en = 1'b1;
    repeat (2) @(negedge clk);
    frame(1);
    check_eq("rr_first_s2", {31'd0, s2_alive}, 32'd1);
    check_eq("rr_first_s1", {31'd0, s1_alive}, 32'd0);
    for (int unsigned k = 1; k <= 9; k++) begin
      frame(1);
      if (k >= 8) check_eq($sformatf("rr_s1_tick%0d", k), {31'd0, s1_alive}, (k == 9) ? 32'd1 : 32'd0);
    end

    // clear together with a hit keeps the hit
    score_clr = 1'b1;
    s1_hit    = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
    s1_hit    = 1'b0;
    check_eq("clr_hit_score", {24'd0, score}, 32'd1);
    check_eq("clr_hit_collect", {31'd0, collect_pulse}, 32'd1);
    @(negedge clk);
    check_eq("collect_one_cycle", {31'd0, collect_pulse}, 32'd0);

    // reset mid-operation
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_s2", {31'd0, s2_alive}, 32'd0);
    check_eq("midrst_score", {24'd0, score}, 32'd0);

    // saturation on the fast instance
    do_reset();
    game_en = 1'b1;
    repeat (2) @(negedge clk);
    frame(1);
    frame(1);
    check_eq("fast_both_alive", {30'd0, f2_alive, f1_alive}, 32'd3);
    for (int unsigned r = 0; r < 127; r++) begin
      f1_hit = 1'b1;
      f2_hit = 1'b1;
      @(negedge clk);
      f1_hit = 1'b0;
      f2_hit = 1'b0;
      check_eq($sformatf("fast_score_r%0d", r), {24'd0, f_score}, 2 * (r + 1));
      repeat (3) frame(1);
    end
    check_eq("fast_refilled", {30'd0, f2_alive, f1_alive}, 32'd3);
    collects = 0;
    f1_hit   = 1'b1;
    f2_hit   = 1'b1;
    @(negedge clk);
    if (f_collect) collects++;
    f1_hit = 1'b0;
    f2_hit = 1'b0;
    @(negedge clk);
    if (f_collect) collects++;
    check_eq("sat_score", {24'd0, f_score}, 32'd255);
    check_eq("sat_collects", collects, 32'd1);
    repeat (3) frame(1);
    f1_hit = 1'b1;
    @(negedge clk);
    f1_hit = 1'b0;
    check_eq("sat_hold_collect", {31'd0, f_collect}, 32'd1);
    check_eq("sat_hold_score", {24'd0, f_score}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
